sr_latch_driver: RTL

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

---
 rtl/sr_latch_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// Pulse-based driver for an external SR latch: guard gap, single-rail drive pulse, optional feedback check.
// Build option: define SR_DRV_VERIFY_EN to add the q_fb synchronizer, the CHECK state and the err flag.
module sr_latch_driver #(
    parameter int GUARD_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int CHECK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int MAX_GP  = (GUARD_CYCLES > PULSE_CYCLES) ? GUARD_CYCLES : PULSE_CYCLES;
    localparam int MAX_ALL = (MAX_GP > CHECK_CYCLES) ? MAX_GP : CHECK_CYCLES;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
`ifdef SR_DRV_VERIFY_EN
    localparam logic [CW-1:0] CHECK_LAST = CW'(CHECK_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
`ifdef SR_DRV_VERIFY_EN
        PULSE = 2'd2,
        CHECK = 2'd3
`else
        PULSE = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          done_q, done_d;
`ifdef SR_DRV_VERIFY_EN
    logic          err_q, err_d;
    logic [1:0]    sync_q, sync_d;
`else
    logic          unused_q_fb;
    assign unused_q_fb = q_fb;
`endif

    // s/r/done are flop outputs so the latch never sees combinational glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef SR_DRV_VERIFY_EN
            err_q   <= 1'b0;
            sync_q  <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
`ifdef SR_DRV_VERIFY_EN
            err_q   <= err_d;
            sync_q  <= sync_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
`ifdef SR_DRV_VERIFY_EN
        err_d   = err_q;
        sync_d  = {sync_q[0], q_fb};
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    level_d = req_level;
`ifdef SR_DRV_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
`ifdef SR_DRV_VERIFY_EN
                    state_d = CHECK;
`else
                    state_d = IDLE;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef SR_DRV_VERIFY_EN
            CHECK: begin
                if (sync_q[1] == level_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CHECK_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Drives are decoded from the next state so they line up with the registered state
    always_comb begin
        s_d    = 1'b0;
        r_d    = 1'b0;
        done_d = 1'b0;
        if (state_d == PULSE) begin
            s_d = level_d;
            r_d = ~level_d;
        end
        if ((state_d == IDLE) && (state_q != IDLE)) begin
            done_d = 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign s         = s_q;
    assign r         = r_q;
    assign done      = done_q;
`ifdef SR_DRV_VERIFY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
